// File: rtl/ram_port_arbiter.sv
// Two-master arbiter in front of the CPU's single-port synchronous data RAM.
// Serialises master accesses into ACC cycles, inserts a CAP cycle after each
// read to capture the RAM output, and returns read data with an rvalid pulse.
module ram_port_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_re,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        CAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;   // master that owns the current ACC/CAP
    logic              last_q, last_d;     // master granted most recently
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              elig0, elig1;
    logic              slot_free;
    logic              win;

    logic              m0_rvalid_q, m1_rvalid_q;
    logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

    // Next state, winner selection and latching of the winner's transaction
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        win     = 1'b0;

        // The master in its gnt cycle still holds req high; it must not win again.
        elig0 = m0_req && !(state_q == ACC && owner_q == 1'b0);
        elig1 = m1_req && !(state_q == ACC && owner_q == 1'b1);

        // A read in ACC always moves to CAP; every other state is a decision point.
        slot_free = (state_q != ACC) || we_q;

        if (elig0 && elig1) begin
            win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        end else begin
            win = elig1;
        end

        if (!slot_free) begin
            state_d = CAP;
        end else if (elig0 || elig1) begin
            state_d = ACC;
            owner_d = win;
            last_d  = win;
            we_d    = win ? m1_we    : m0_we;
            addr_d  = win ? m1_addr  : m0_addr;
            wdata_d = win ? m1_wdata : m0_wdata;
        end else begin
            state_d = IDLE;
        end
    end

    // State register, arbitration pointer and latched transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;   // master 1 counts as most recent, so master 0 wins the first tie
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Capture RAM read data at the end of CAP and pulse the owner's rvalid next cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: data registers usually skip reset; these are reset because rdata must read 0 in reset.
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            m0_rvalid_q <= (state_q == CAP) && (owner_q == 1'b0);
            m1_rvalid_q <= (state_q == CAP) && (owner_q == 1'b1);
            if (state_q == CAP && owner_q == 1'b0) begin
                m0_rdata_q <= ram_rdata;
            end
            if (state_q == CAP && owner_q == 1'b1) begin
                m1_rdata_q <= ram_rdata;
            end
        end
    end

    // Address and write data come straight from the latch, so they hold outside ACC.
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = (state_q == ACC) &&  we_q;
    assign ram_re    = (state_q == ACC) && !we_q;

    assign m0_gnt    = (state_q == ACC) && (owner_q == 1'b0);
    assign m1_gnt    = (state_q == ACC) && (owner_q == 1'b1);
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a round-robin instance and a fixed-priority
// instance share the master inputs, each with its own synchronous RAM model.
// Directed scenarios plus a random run checked against a transaction-level
// model (shadow memory, grant-to-rvalid latency, wait bound).
module tb_ram_port_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [5:0]  m0_addr, m1_addr;
    logic [15:0] m0_wdata, m1_wdata;

    logic        rr_m0_gnt, rr_m1_gnt, rr_m0_rvalid, rr_m1_rvalid;
    logic [15:0] rr_m0_rdata, rr_m1_rdata, rr_ram_wdata, rr_ram_rdata;
    logic [5:0]  rr_ram_addr;
    logic        rr_ram_we, rr_ram_re, rr_busy;

    logic        fx_m0_gnt, fx_m1_gnt, fx_m0_rvalid, fx_m1_rvalid;
    logic [15:0] fx_m0_rdata, fx_m1_rdata, fx_ram_wdata, fx_ram_rdata;
    logic [5:0]  fx_ram_addr;
    logic        fx_ram_we, fx_ram_re, fx_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          m;
        logic        known;
        logic [15:0] data;
        int          due;
    } rd_t;

    ram_port_arbiter #(.ADDR_W(6), .DATA_W(16), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(rr_m0_gnt), .m0_rvalid(rr_m0_rvalid), .m0_rdata(rr_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(rr_m1_gnt), .m1_rvalid(rr_m1_rvalid), .m1_rdata(rr_m1_rdata),
        .ram_addr(rr_ram_addr), .ram_we(rr_ram_we), .ram_re(rr_ram_re),
        .ram_wdata(rr_ram_wdata), .ram_rdata(rr_ram_rdata), .busy(rr_busy)
    );

    ram_port_arbiter #(.ADDR_W(6), .DATA_W(16), .FIXED_PRIO(1)) u_fx (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(fx_m0_gnt), .m0_rvalid(fx_m0_rvalid), .m0_rdata(fx_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(fx_m1_gnt), .m1_rvalid(fx_m1_rvalid), .m1_rdata(fx_m1_rdata),
        .ram_addr(fx_ram_addr), .ram_we(fx_ram_we), .ram_re(fx_ram_re),
        .ram_wdata(fx_ram_wdata), .ram_rdata(fx_ram_rdata), .busy(fx_busy)
    );

    // Synchronous single-port RAMs, 64x16
    logic [15:0] mem_rr [64];
    logic [15:0] mem_fx [64];

    always @(posedge clk) begin
        if (rr_ram_we) mem_rr[rr_ram_addr] <= rr_ram_wdata;
        if (rr_ram_re) rr_ram_rdata <= mem_rr[rr_ram_addr];
    end

    always @(posedge clk) begin
        if (fx_ram_we) mem_fx[fx_ram_addr] <= fx_ram_wdata;
        if (fx_ram_re) fx_ram_rdata <= mem_fx[fx_ram_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int m, input logic req, input logic we,
                              input logic [5:0] addr, input logic [15:0] wdata);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    function automatic logic [60:0] rr_outs();
        return {rr_m0_gnt, rr_m1_gnt, rr_m0_rvalid, rr_m1_rvalid, rr_ram_we, rr_ram_re,
                rr_busy, rr_ram_addr, rr_ram_wdata, rr_m0_rdata, rr_m1_rdata};
    endfunction

    function automatic logic [60:0] fx_outs();
        return {fx_m0_gnt, fx_m1_gnt, fx_m0_rvalid, fx_m1_rvalid, fx_ram_we, fx_ram_re,
                fx_busy, fx_ram_addr, fx_ram_wdata, fx_m0_rdata, fx_m1_rdata};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        set_master(0, 1'b0, 1'b0, 6'h00, 16'h0000);
        set_master(1, 1'b0, 1'b0, 6'h00, 16'h0000);
        #1 reset = 1'b0;
        #2;
        checks++; if (rr_outs() !== '0) begin errors++; $display("FAIL reset_rr: got %h expected 0", rr_outs()); end
        checks++; if (fx_outs() !== '0) begin errors++; $display("FAIL reset_fx: got %h expected 0", fx_outs()); end
        @(posedge clk); @(posedge clk); #1;
        checks++; if (rr_outs() !== '0) begin errors++; $display("FAIL reset_clocked: got %h expected 0", rr_outs()); end
        reset = 1'b1;

        // Put known data at 0x10, then start a read of it and reset during CAP.
        set_master(0, 1'b1, 1'b1, 6'h10, 16'hA5A5);
        tick(); tick();
        set_master(0, 1'b1, 1'b0, 6'h10, 16'h0000);
        tick();
        checks++; if ({rr_m0_gnt, rr_ram_re} !== 2'b11) begin errors++; $display("FAIL reset_pre_read_gnt: got %b expected 11", {rr_m0_gnt, rr_ram_re}); end
        tick();
        set_master(0, 1'b0, 1'b0, 6'h00, 16'h0000);
        checks++; if ({rr_busy, rr_m0_gnt, rr_ram_re} !== 3'b100) begin errors++; $display("FAIL reset_in_cap: got %b expected 100", {rr_busy, rr_m0_gnt, rr_ram_re}); end
        #2 reset = 1'b0;
        #1;
        checks++; if (rr_outs() !== '0) begin errors++; $display("FAIL reset_mid_read: got %h expected 0", rr_outs()); end
        @(posedge clk); @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (rr_m0_rvalid !== 1'b0) begin errors++; $display("FAIL reset_no_rvalid: got %b expected 0 (cycle %0d)", rr_m0_rvalid, i); end
        end
        set_master(0, 1'b1, 1'b1, 6'h11, 16'h0001);
        tick();
        checks++; if ({rr_m0_gnt, rr_ram_we} !== 2'b11) begin errors++; $display("FAIL reset_first_gnt: got %b expected 11", {rr_m0_gnt, rr_ram_we}); end
        tick();
        set_master(0, 1'b0, 1'b0, 6'h00, 16'h0000);
        tick();
    endtask

    task automatic test_write_read();
        set_master(0, 1'b1, 1'b1, 6'h05, 16'hBEEF);
        tick();
        checks++;
        if ({rr_m0_gnt, rr_m1_gnt, rr_ram_we, rr_ram_re, rr_ram_addr, rr_ram_wdata} !== {4'b1010, 6'h05, 16'hBEEF}) begin
            errors++; $display("FAIL write_strobes: got %b %h %h expected 1010 05 beef",
                               {rr_m0_gnt, rr_m1_gnt, rr_ram_we, rr_ram_re}, rr_ram_addr, rr_ram_wdata);
        end
        tick();
        set_master(0, 1'b0, 1'b0, 6'h00, 16'h0000);
        checks++; if ({rr_ram_we, rr_m0_gnt} !== 2'b00) begin errors++; $display("FAIL write_one_cycle: got %b expected 00", {rr_ram_we, rr_m0_gnt}); end
        set_master(0, 1'b1, 1'b0, 6'h05, 16'h0000);
        tick();
        checks++;
        if ({rr_m0_gnt, rr_ram_we, rr_ram_re, rr_ram_addr} !== {3'b101, 6'h05}) begin
            errors++; $display("FAIL read_strobes: got %b %h expected 101 05", {rr_m0_gnt, rr_ram_we, rr_ram_re}, rr_ram_addr);
        end
        tick();
        set_master(0, 1'b0, 1'b0, 6'h00, 16'h0000);
        checks++; if (rr_m0_rvalid !== 1'b0) begin errors++; $display("FAIL read_early_rvalid: got %b expected 0", rr_m0_rvalid); end
        tick();
        checks++; if ({rr_m0_rvalid, rr_m0_rdata} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL read_data: got %b %h expected 1 beef", rr_m0_rvalid, rr_m0_rdata); end
        tick();
        checks++; if ({rr_m0_rvalid, rr_m0_rdata} !== {1'b0, 16'hBEEF}) begin errors++; $display("FAIL read_hold: got %b %h expected 0 beef", rr_m0_rvalid, rr_m0_rdata); end
    endtask

    task automatic test_contention_rr();
        int k0 = 0;
        int k1 = 0;
        logic g0p = 1'b0;
        logic g1p = 1'b0;
        logic [5:0]  ea;
        logic [15:0] ed;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_master(0, 1'b1, 1'b1, 6'h20, 16'h1000);
        set_master(1, 1'b1, 1'b1, 6'h30, 16'h2000);
        for (int c = 0; c < 8; c++) begin
            tick();
            if (g0p) begin
                k0++;
                if (k0 < 4) set_master(0, 1'b1, 1'b1, 6'(32 + k0), 16'(4096 + k0));
                else        set_master(0, 1'b0, 1'b0, 6'h00, 16'h0000);
            end
            if (g1p) begin
                k1++;
                if (k1 < 4) set_master(1, 1'b1, 1'b1, 6'(48 + k1), 16'(8192 + k1));
                else        set_master(1, 1'b0, 1'b0, 6'h00, 16'h0000);
            end
            g0p = rr_m0_gnt;
            g1p = rr_m1_gnt;
            ea = 6'(((c % 2 == 0) ? 32 : 48) + c / 2);
            ed = 16'(((c % 2 == 0) ? 4096 : 8192) + c / 2);
            checks++;
            if ({rr_m0_gnt, rr_m1_gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rr_order: cycle %0d got %b expected %b", c, {rr_m0_gnt, rr_m1_gnt}, (c % 2 == 0) ? 2'b10 : 2'b01);
            end
            checks++;
            if ({rr_ram_we, rr_ram_re, rr_ram_addr, rr_ram_wdata} !== {2'b10, ea, ed}) begin
                errors++; $display("FAIL rr_access: cycle %0d got %b %h %h expected 10 %h %h", c,
                                   {rr_ram_we, rr_ram_re}, rr_ram_addr, rr_ram_wdata, ea, ed);
            end
        end
        tick();
        if (g1p) set_master(1, 1'b0, 1'b0, 6'h00, 16'h0000);
        checks++; if ({rr_busy, rr_ram_we, rr_ram_re} !== 3'b000) begin errors++; $display("FAIL rr_drain: got %b expected 000", {rr_busy, rr_ram_we, rr_ram_re}); end
        tick();
    endtask

    task automatic test_fixed_prio();
        logic [1:0] exp_tab [8] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        int   k0  = 0;
        logic g0p = 1'b0;
        logic g1p = 1'b0;
        set_master(0, 1'b1, 1'b0, 6'h01, 16'h0000);
        set_master(1, 1'b1, 1'b0, 6'h02, 16'h0000);
        for (int c = 0; c < 8; c++) begin
            tick();
            if (g0p) begin
                k0++;
                if (k0 < 3) set_master(0, 1'b1, 1'b0, 6'(1 + k0), 16'h0000);
                else        set_master(0, 1'b0, 1'b0, 6'h00, 16'h0000);
            end
            if (g1p) set_master(1, 1'b0, 1'b0, 6'h00, 16'h0000);
            g0p = fx_m0_gnt;
            g1p = fx_m1_gnt;
            checks++;
            if ({fx_m0_gnt, fx_m1_gnt} !== exp_tab[c]) begin
                errors++; $display("FAIL fixed_order: cycle %0d got %b expected %b", c, {fx_m0_gnt, fx_m1_gnt}, exp_tab[c]);
            end
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_interleave();
        set_master(1, 1'b1, 1'b1, 6'h3F, 16'h1234);
        tick();
        checks++; if ({rr_m1_gnt, rr_ram_we, rr_ram_addr} !== {2'b11, 6'h3F}) begin errors++; $display("FAIL il_write_3f: got %b %h expected 11 3f", {rr_m1_gnt, rr_ram_we}, rr_ram_addr); end
        tick();
        set_master(1, 1'b1, 1'b0, 6'h3F, 16'h0000);
        tick();
        checks++; if ({rr_m1_gnt, rr_ram_re, rr_ram_addr} !== {2'b11, 6'h3F}) begin errors++; $display("FAIL il_read_acc: got %b %h expected 11 3f", {rr_m1_gnt, rr_ram_re}, rr_ram_addr); end
        set_master(0, 1'b1, 1'b1, 6'h00, 16'h5A5A);
        tick();
        set_master(1, 1'b0, 1'b0, 6'h00, 16'h0000);
        checks++;
        if ({rr_busy, rr_m0_gnt, rr_m1_gnt, rr_ram_we, rr_ram_re} !== 5'b10000) begin
            errors++; $display("FAIL il_cap: got %b expected 10000", {rr_busy, rr_m0_gnt, rr_m1_gnt, rr_ram_we, rr_ram_re});
        end
        tick();
        checks++;
        if ({rr_m0_gnt, rr_ram_we, rr_ram_addr, rr_ram_wdata} !== {2'b11, 6'h00, 16'h5A5A}) begin
            errors++; $display("FAIL il_m0_write: got %b %h %h expected 11 00 5a5a", {rr_m0_gnt, rr_ram_we}, rr_ram_addr, rr_ram_wdata);
        end
        checks++; if ({rr_m1_rvalid, rr_m1_rdata} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL il_rvalid_overlap: got %b %h expected 1 1234", rr_m1_rvalid, rr_m1_rdata); end
        tick();
        set_master(0, 1'b0, 1'b0, 6'h00, 16'h0000);
        checks++; if (rr_m1_rvalid !== 1'b0) begin errors++; $display("FAIL il_rvalid_pulse: got %b expected 0", rr_m1_rvalid); end
        set_master(1, 1'b1, 1'b0, 6'h00, 16'h0000);
        tick();
        tick();
        set_master(1, 1'b0, 1'b0, 6'h00, 16'h0000);
        tick();
        checks++; if ({rr_m1_rvalid, rr_m1_rdata} !== {1'b1, 16'h5A5A}) begin errors++; $display("FAIL il_read_00: got %b %h expected 1 5a5a", rr_m1_rvalid, rr_m1_rdata); end
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_random();
        logic        pend  [2];
        logic        gprev [2];
        logic        t_we  [2];
        logic [5:0]  t_addr[2];
        logic [15:0] t_wd  [2];
        int          age   [2];
        logic [15:0] shadow[64];
        bit          known [64];
        rd_t         q[$];
        rd_t         it;
        logic [1:0]  g, rv, exp_rv;
        logic [15:0] act;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; gprev[m] = 1'b0; age[m] = 0;
            t_we[m] = 1'b0; t_addr[m] = '0; t_wd[m] = '0;
        end
        for (int a = 0; a < 64; a++) begin
            known[a] = 1'b0; shadow[a] = '0;
        end
        it = '{m: 0, known: 1'b0, data: 16'h0000, due: -1};
        for (int cyc = 0; cyc < 1012; cyc++) begin
            tick();
            // Retire transactions granted last cycle, then maybe start new ones.
            for (int m = 0; m < 2; m++) begin
                if (gprev[m]) begin
                    pend[m] = 1'b0; gprev[m] = 1'b0;
                    set_master(m, 1'b0, 1'b0, 6'h00, 16'h0000);
                end
                if (!pend[m] && cyc < 1000 && $urandom_range(9, 0) < 6) begin
                    t_we[m]   = 1'($urandom_range(1, 0));
                    t_addr[m] = 6'($urandom_range(63, 0));
                    t_wd[m]   = 16'($urandom_range(65535, 0));
                    pend[m] = 1'b1; age[m] = 0;
                    set_master(m, 1'b1, t_we[m], t_addr[m], t_wd[m]);
                end
            end
            checks++;
            if ((rr_m0_gnt && rr_m1_gnt) || (rr_ram_we && rr_ram_re)) begin
                errors++; $display("FAIL rand_exclusive: cycle %0d gnt %b%b we %b re %b", cyc, rr_m0_gnt, rr_m1_gnt, rr_ram_we, rr_ram_re);
            end
            g = {rr_m1_gnt, rr_m0_gnt};
            for (int m = 0; m < 2; m++) begin
                if (g[m]) begin
                    checks++;
                    if (!pend[m] || age[m] == 0) begin
                        errors++; $display("FAIL rand_unrequested_gnt: cycle %0d master %0d pending %b age %0d", cyc, m, pend[m], age[m]);
                    end else begin
                        checks++;
                        if ({rr_ram_we, rr_ram_re, rr_ram_addr} !== {t_we[m], ~t_we[m], t_addr[m]}) begin
                            errors++; $display("FAIL rand_access: cycle %0d master %0d got we%b re%b %h expected we%b %h",
                                               cyc, m, rr_ram_we, rr_ram_re, rr_ram_addr, t_we[m], t_addr[m]);
                        end
                        if (t_we[m]) begin
                            checks++;
                            if (rr_ram_wdata !== t_wd[m]) begin
                                errors++; $display("FAIL rand_wdata: cycle %0d master %0d got %h expected %h", cyc, m, rr_ram_wdata, t_wd[m]);
                            end
                            shadow[t_addr[m]] = t_wd[m];
                            known[t_addr[m]]  = 1'b1;
                        end else begin
                            q.push_back('{m: m, known: known[t_addr[m]], data: shadow[t_addr[m]], due: cyc + 2});
                        end
                    end
                    gprev[m] = 1'b1;
                end else if (pend[m]) begin
                    age[m]++;
                    if (age[m] >= 6) begin
                        errors++; $display("FAIL rand_wait_bound: cycle %0d master %0d waited %0d cycles", cyc, m, age[m]);
                        pend[m] = 1'b0;
                        set_master(m, 1'b0, 1'b0, 6'h00, 16'h0000);
                    end
                end
            end
            if (g == 2'b00) begin
                checks++;
                if ({rr_ram_we, rr_ram_re} !== 2'b00) begin
                    errors++; $display("FAIL rand_idle_strobes: cycle %0d got %b expected 00", cyc, {rr_ram_we, rr_ram_re});
                end
            end
            exp_rv = 2'b00;
            if (q.size() > 0 && q[0].due == cyc) begin
                it = q.pop_front();
                exp_rv[it.m] = 1'b1;
            end
            rv = {rr_m1_rvalid, rr_m0_rvalid};
            checks++;
            if (rv !== exp_rv) begin
                errors++; $display("FAIL rand_rvalid: cycle %0d got %b expected %b", cyc, rv, exp_rv);
            end
            if (exp_rv != 2'b00 && it.known) begin
                act = (it.m == 1) ? rr_m1_rdata : rr_m0_rdata;
                checks++;
                if (act !== it.data) begin
                    errors++; $display("FAIL rand_rdata: cycle %0d master %0d got %h expected %h", cyc, it.m, act, it.data);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL rand_lost_reads: got %0d outstanding expected 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contention_rr();
        test_fixed_prio();
        test_interleave();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
